// File: rtl/sync_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sync_rr_scheduler_pkg
//   Shared defaults and helpers for the round-robin scheduler slice.
//   Contents:
//     N_DEFAULT, W_DEFAULT, DEPTH_DEFAULT : default requester count,
//                                           operand width and tag FIFO depth
//     clog2_min1()                        : index width that is never zero
// -----------------------------------------------------------------------------
package sync_rr_scheduler_pkg;

  localparam int N_DEFAULT     = 4;
  localparam int W_DEFAULT     = 16;
  localparam int DEPTH_DEFAULT = 4;

  // Width needed to index 'n' items.  It is never zero, so a 1-entry range
  // still produces a legal 1-bit vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_tag_fifo.sv
// -----------------------------------------------------------------------------
// sync_tag_fifo
//   Small FIFO that holds requester tags for transactions that are in flight
//   through the shared function unit.  Storage is registered.  The head is
//   read combinationally, so the response path can route a result in the
//   same cycle it arrives.  There is no bypass: a tag pushed in a cycle
//   becomes visible at the head in the following cycle at the earliest.
//   Ports:
//     clk        in   clock, all state on posedge
//     nrst       in   asynchronous active-low reset (empties the FIFO)
//     push       in   write push_data (ignored when full)
//     push_data  in   tag to store
//     pop        in   drop the head entry (ignored when empty)
//     full       out  occupancy == DEPTH (start-of-cycle value)
//     empty      out  occupancy == 0
//     head       out  oldest stored tag
// -----------------------------------------------------------------------------
module sync_tag_fifo
  import sync_rr_scheduler_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int            AW         = clog2_min1(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_reg[rd_ptr_reg];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry contents are only meaningful between the pointers, so the
  // storage array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/sync_rr_scheduler.sv
// -----------------------------------------------------------------------------
// sync_rr_scheduler
//   Shares one in-order synchronous function unit between N requesters.
//   A rotating-priority arbiter picks one requester and forwards its operand
//   over the unit's valid/ready input.  The requester index is queued in a
//   tag FIFO, and each result coming back is steered to the requester at the
//   FIFO head.
//   Ports:
//     clk, nrst                 clock / asynchronous active-low reset
//     req_valid/ready/data      N request channels (data packed N*W)
//     rsp_valid/ready, rsp_data N response channels, one shared data bus
//     fn_in_valid/ready, fn_in0 operand handshake toward the unit
//     fn_out_valid/ready, fn_out0 result handshake from the unit
//     busy                      transactions outstanding (tag FIFO not empty)
//     err                       sticky: a result arrived with no tag queued
// -----------------------------------------------------------------------------
module sync_rr_scheduler
  import sync_rr_scheduler_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   rsp_valid,
  input  logic [N-1:0]   rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic           fn_in_valid,
  input  logic           fn_in_ready,
  output logic [W-1:0]   fn_in0,
  input  logic           fn_out_valid,
  output logic           fn_out_ready,
  input  logic [W-1:0]   fn_out0,
  output logic           busy,
  output logic           err
);

  localparam int               TAG_W    = clog2_min1(N);
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(N-1);
  localparam logic [TAG_W:0]   N_WIDE   = (TAG_W+1)'(N);

  logic [TAG_W-1:0] ptr_reg;
  logic [TAG_W-1:0] ptr_next;
  logic [TAG_W-1:0] grant_idx;
  logic             grant_found;
  logic [TAG_W:0]   cand;
  logic             run_reg;
  logic             err_reg;
  logic             can_issue;
  logic             issue_fire;
  logic             pop_fire;
  logic             rsp_any;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TAG_W-1:0] head_tag;

  // Rotating priority search: the first valid requester starting at ptr_reg,
  // wrapping modulo N.  The extra bit in 'cand' holds ptr+k before the wrap.
  always_comb begin
    grant_idx   = ptr_reg;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_reg} + (TAG_W+1)'(k);
      if (cand >= N_WIDE) cand = cand - N_WIDE;
      if (!grant_found && req_valid[cand[TAG_W-1:0]]) begin
        grant_idx   = cand[TAG_W-1:0];
        grant_found = 1'b1;
      end
    end
  end

  // run_reg keeps the request side quiet while reset is held and until the
  // first clock after release.  fn_in_valid never looks at fn_in_ready, so
  // there is no combinational path through the unit's handshake.
  assign can_issue   = run_reg & grant_found & ~fifo_full;
  assign fn_in_valid = can_issue;
  assign fn_in0      = req_data[grant_idx*W +: W];
  assign issue_fire  = can_issue & fn_in_ready;

  // Response routing follows the oldest outstanding tag.
  assign rsp_any      = fn_out_valid & ~fifo_empty;
  assign fn_out_ready = ~fifo_empty & rsp_ready[head_tag];
  assign pop_fire     = fn_out_valid & fn_out_ready;
  assign rsp_data     = fn_out0;
  assign busy         = ~fifo_empty;
  assign err          = err_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign req_ready[gi] = issue_fire & (grant_idx == TAG_W'(gi));
    assign rsp_valid[gi] = rsp_any & (head_tag == TAG_W'(gi));
  end

  // After a grant the requester just served gets the lowest priority.
  always_comb begin
    ptr_next = ptr_reg;
    if (issue_fire) ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr_reg <= '0;
      run_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
      run_reg <= 1'b1;
      if (fn_out_valid && fifo_empty) err_reg <= 1'b1;
    end
  end

  sync_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (issue_fire),
    .push_data (grant_idx),
    .pop       (pop_fire),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_tag)
  );

endmodule

// File: tb/tb_sync_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sync_rr_scheduler
//   Bench for sync_rr_scheduler with a Fibonacci function unit that stays in
//   order and can be stalled.  Each issue pushes {requester, fib(operand)}
//   into a scoreboard, and each response pops an entry and compares it.
//   Expected grant order is queued by the stimulus.
// -----------------------------------------------------------------------------
module tb_sync_rr_scheduler;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]   idx;
    logic [W-1:0] data;
  } sb_entry_t;

  logic           clk = 1'b0;
  logic           nrst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_data;
  logic           fn_in_valid;
  logic           fn_in_ready;
  logic [W-1:0]   fn_in0;
  logic           fn_out_valid;
  logic           fn_out_ready;
  logic [W-1:0]   fn_out0;
  logic           busy;
  logic           err;

  int n_checks  = 0;
  int n_fail    = 0;
  int issue_cnt = 0;
  int rsp_cnt   = 0;

  sb_entry_t    sb_q[$];
  int           exp_grant_q[$];
  logic [W-1:0] unit_q[$];

  logic         unit_en;
  logic         spur;
  logic         unit_has = 1'b0;
  logic [W-1:0] unit_head = '0;
  logic         in_fire_pend = 1'b0;
  logic         out_fire_pend = 1'b0;
  logic [W-1:0] in_data_pend = '0;

  always #5 clk = ~clk;

  assign fn_out_valid = spur | (unit_en & unit_has);
  assign fn_out0      = unit_head;

  sync_rr_scheduler #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .fn_in_valid  (fn_in_valid),
    .fn_in_ready  (fn_in_ready),
    .fn_in0       (fn_in0),
    .fn_out_valid (fn_out_valid),
    .fn_out_ready (fn_out_ready),
    .fn_out0      (fn_out0),
    .busy         (busy),
    .err          (err)
  );

  function automatic logic [W-1:0] fib(input logic [W-1:0] n);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] t;
    a = '0;
    b = W'(1);
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transfers are detected mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin : monitor
    int        g;
    sb_entry_t e;
    in_fire_pend  = 1'b0;
    out_fire_pend = 1'b0;
    if (!nrst) begin
      sb_q.delete();
    end else begin
      if (fn_in_valid && fn_in_ready) begin
        g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        check_eq("grant_onehot", $countones(req_ready), 1);
        if (exp_grant_q.size() > 0) check_eq("grant_order", g, exp_grant_q.pop_front());
        check_eq("fn_in0", fn_in0, req_data[g*W +: W]);
        e.idx  = 2'(g);
        e.data = fib(req_data[g*W +: W]);
        sb_q.push_back(e);
        in_data_pend = fn_in0;
        in_fire_pend = 1'b1;
        issue_cnt++;
        $display("issue    req=%0d operand=%0d", g, req_data[g*W +: W]);
      end
      if (fn_out_valid && fn_out_ready) begin
        out_fire_pend = 1'b1;
        rsp_cnt++;
        if (sb_q.size() == 0) begin
          check_eq("rsp_unexpected", rsp_cnt, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq("rsp_valid", rsp_valid, 32'(1) << e.idx);
          check_eq("rsp_data", rsp_data, e.data);
          $display("response req=%0d result=%0d", e.idx, rsp_data);
        end
      end
    end
  end

  // In-order function unit: a result is available from the cycle after issue.
  always @(posedge clk) begin
    if (!nrst) begin
      unit_q.delete();
    end else begin
      if (out_fire_pend && unit_q.size() > 0) void'(unit_q.pop_front());
      if (in_fire_pend) unit_q.push_back(fib(in_data_pend));
    end
    unit_has  <= (unit_q.size() > 0);
    unit_head <= (unit_q.size() > 0) ? unit_q[0] : '0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_mask(input logic [N-1:0] mask, input int n);
    int start;
    start     = issue_cnt;
    req_valid = mask;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (issue_cnt - start >= n) break;
    end
    req_valid = '0;
    check_eq("issue_count", issue_cnt - start, n);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && sb_q.size() > 0; k++) tick(1);
    check_eq("drain_left", sb_q.size(), 0);
    check_eq("busy_after_drain", busy, 0);
  endtask

  initial begin : stim
    int start3;
    int start_rsp;
    nrst        = 1'b1;
    req_valid   = '0;
    req_data    = '0;
    rsp_ready   = '1;
    fn_in_ready = 1'b1;
    unit_en     = 1'b0;
    spur        = 1'b0;

    // Reset held with every requester asking.
    #1 nrst = 1'b0;
    req_valid = '1;
    tick(3);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_fn_in_valid", fn_in_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_fn_out_ready", fn_out_ready, 0);
    req_valid = '0;
    nrst = 1'b1;
    tick(2);

    // Single requester: fib(10) = 55 returned to requester 2.
    unit_en = 1'b1;
    req_data[2*W +: W] = W'(10);
    exp_grant_q.push_back(2);
    issue_mask(4'b0100, 1);
    wait_drain();

    // Round robin from a fresh pointer with the unit stalled, then fill.
    nrst = 1'b0;
    tick(1);
    nrst = 1'b1;
    tick(2);
    unit_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = W'(i + 3);
      exp_grant_q.push_back(i);
    end
    start3 = issue_cnt;
    req_valid = '1;
    tick(4);
    check_eq("rr_issued4", issue_cnt - start3, 4);
    check_eq("full_blocks_issue", fn_in_valid, 0);
    check_eq("full_busy", busy, 1);
    tick(2);
    check_eq("full_holds", issue_cnt - start3, 4);
    exp_grant_q.push_back(0);
    unit_en = 1'b1;
    check_eq("full_during_pop", fn_in_valid, 0);
    issue_mask('1, 1);
    wait_drain();

    // Pointer wrap: steer ptr to 3, then requesters 3 and 0.
    req_data[2*W +: W] = W'(7);
    exp_grant_q.push_back(2);
    issue_mask(4'b0100, 1);
    req_data[0*W +: W] = W'(8);
    req_data[3*W +: W] = W'(9);
    exp_grant_q.push_back(3);
    exp_grant_q.push_back(0);
    issue_mask(4'b1001, 2);
    exp_grant_q.push_back(1);
    issue_mask(4'b1111, 1);
    wait_drain();

    // Back-pressure: requester 2 refuses its result while at the head.
    unit_en = 1'b0;
    req_data[2*W +: W] = W'(5);
    exp_grant_q.push_back(2);
    issue_mask(4'b0100, 1);
    req_data[1*W +: W] = W'(6);
    exp_grant_q.push_back(1);
    issue_mask(4'b0010, 1);
    req_data[3*W +: W] = W'(20);
    exp_grant_q.push_back(3);
    issue_mask(4'b1000, 1);
    start_rsp = rsp_cnt;
    rsp_ready = 4'b1011;
    unit_en = 1'b1;
    tick(10);
    check_eq("bp_out_ready", fn_out_ready, 0);
    check_eq("bp_rsp_valid", rsp_valid, 4'b0100);
    check_eq("bp_rsp_data", rsp_data, fib(W'(5)));
    check_eq("bp_no_pop", rsp_cnt - start_rsp, 0);
    check_eq("bp_busy", busy, 1);
    rsp_ready = '1;
    wait_drain();

    // Spurious result with nothing outstanding.
    unit_en = 1'b0;
    spur = 1'b1;
    #1;
    check_eq("spur_rsp_valid", rsp_valid, 0);
    check_eq("spur_out_ready", fn_out_ready, 0);
    tick(1);
    spur = 1'b0;
    check_eq("spur_err", err, 1);
    tick(3);
    check_eq("err_sticky", err, 1);

    // Reset asserted mid-stream clears FIFO and err at once.
    req_data[0*W +: W] = W'(3);
    exp_grant_q.push_back(0);
    issue_mask(4'b0001, 1);
    req_data[1*W +: W] = W'(4);
    exp_grant_q.push_back(1);
    issue_mask(4'b0010, 1);
    check_eq("midstream_busy", busy, 1);
    req_valid = '1;
    #2 nrst = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_err", err, 0);
    check_eq("midrst_fn_in_valid", fn_in_valid, 0);
    check_eq("midrst_req_ready", req_ready, 0);
    tick(2);
    req_valid = '0;
    nrst = 1'b1;
    tick(2);

    // Normal traffic resumes after the reset.
    unit_en = 1'b1;
    req_data[1*W +: W] = W'(12);
    exp_grant_q.push_back(1);
    issue_mask(4'b0010, 1);
    wait_drain();
    check_eq("grants_left", exp_grant_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
